// File: rtl/loopback_checker.sv
// rtl/loopback_checker.sv - PRBS7 pin loopback checker with latency search; optional error injection under LOOPBACK_ERR_INJECT_EN
module loopback_checker #(
   parameter int DIV         = 50,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_LAT     = 7,
   parameter int LOCK_LEN    = 16,
   parameter int ERR_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_expect_inv,
   input  logic             i_rx_in,
`ifdef LOOPBACK_ERR_INJECT_EN
   input  logic             i_inject_err,
`endif
   output logic             o_tx_out,
   output logic             o_busy,
   output logic             o_locked,
   output logic [2:0]       o_lat,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic             o_fail
);

   localparam int CNT_W   = $clog2(DIV);
   localparam int MATCH_W = $clog2(LOCK_LEN + 1);
   localparam int WARM_W  = $clog2(MAX_LAT + 2);
   localparam int HIST_W  = MAX_LAT + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_RUN,
      ST_FAIL
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [6:0]             r_lfsr;
   logic [HIST_W-1:0]      r_hist;
   logic                   r_tx;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [2:0]             r_cand;
   logic [MATCH_W-1:0]     r_match;
   logic [WARM_W-1:0]      r_warm;
   logic [2:0]             r_lat;
   logic [ERR_W-1:0]       r_err;
   logic                   r_fail;

   logic w_busy;
   logic w_stay_busy;
   logic w_tick;
   logic w_strobe;
   logic w_check;
   logic w_rx_s;
   logic w_exp;
   logic w_hit;
   logic w_enter_align;
   logic w_lock;
   logic w_give_up;
   logic w_err;
   logic w_new_bit;
   logic w_inj_flip;

   assign w_rx_s    = r_sync[SYNC_STAGES-1];
   assign w_new_bit = r_lfsr[5];

   // Next-state logic plus the per-cycle event flags that drive the datapath
   always_comb begin
      w_state_nxt   = r_state;
      w_busy        = (r_state == ST_ALIGN) || (r_state == ST_RUN);
      w_tick        = w_busy && (r_cnt == CNT_W'(DIV - 1));
      w_strobe      = w_busy && (r_cnt == CNT_W'(DIV / 2));
      w_check       = w_strobe && (r_warm == WARM_W'(MAX_LAT + 1));
      w_exp         = r_hist[r_cand] ^ i_expect_inv;
      w_hit         = (w_rx_s == w_exp);
      w_enter_align = (r_state == ST_IDLE) && i_start;
      w_lock        = (r_state == ST_ALIGN) && i_start && w_check && w_hit &&
                      (r_match == MATCH_W'(LOCK_LEN - 1));
      w_give_up     = (r_state == ST_ALIGN) && i_start && w_check && !w_hit &&
                      (r_cand == 3'(MAX_LAT));
      w_err         = (r_state == ST_RUN) && i_start && w_strobe && !w_hit;
      case (r_state)
         ST_IDLE:  if (i_start) w_state_nxt = ST_ALIGN;
         ST_ALIGN: begin
            if (!i_start)       w_state_nxt = ST_IDLE;
            else if (w_lock)    w_state_nxt = ST_RUN;
            else if (w_give_up) w_state_nxt = ST_FAIL;
         end
         ST_RUN:   if (!i_start) w_state_nxt = ST_IDLE;
         ST_FAIL:  if (!i_start) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      w_stay_busy = (w_state_nxt == ST_ALIGN) || (w_state_nxt == ST_RUN);
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Bit timer: free-runs only while the test stays active, otherwise parked at 0
   always_ff @(posedge i_clk) begin
      if (i_rst || !(w_busy && w_stay_busy))  r_cnt <= '0;
      else if (r_cnt == CNT_W'(DIV - 1))      r_cnt <= '0;
      else                                    r_cnt <= r_cnt + CNT_W'(1);
   end

   // rx_in is asynchronous; only the last synchronizer stage feeds the compare
   always_ff @(posedge i_clk) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_in};
   end

   // PRBS7 generator, transmit register and history of transmitted bits
   always_ff @(posedge i_clk) begin
      if (i_rst || w_enter_align) begin
         r_lfsr <= 7'h7F;
         r_hist <= '0;
         r_tx   <= 1'b0;
      end else if (!w_stay_busy) begin
         r_tx   <= 1'b0;
      end else if (w_tick) begin
         r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
         r_hist <= {r_hist[HIST_W-2:0], w_new_bit};
         r_tx   <= w_new_bit ^ w_inj_flip;
      end
   end

   // Latency search: warm-up tick count, candidate latency and match run length
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cand  <= '0;
         r_match <= '0;
         r_warm  <= '0;
         r_lat   <= '0;
      end else if (w_enter_align) begin
         r_cand  <= '0;
         r_match <= '0;
         r_warm  <= '0;
      end else if ((r_state == ST_ALIGN) && i_start) begin
         if (w_tick && (r_warm != WARM_W'(MAX_LAT + 1)))
            r_warm <= r_warm + WARM_W'(1);
         if (w_check) begin
            if (w_hit) begin
               r_match <= r_match + MATCH_W'(1);
               if (w_lock) r_lat <= r_cand;
            end else begin
               r_match <= '0;
               if (r_cand != 3'(MAX_LAT)) r_cand <= r_cand + 3'd1;
            end
         end
      end
   end

   // Saturating error counter; cleared only when a new search starts
   always_ff @(posedge i_clk) begin
      if (i_rst || w_enter_align)    r_err <= '0;
      else if (w_err && (r_err != '1)) r_err <= r_err + ERR_W'(1);
   end

   // Sticky no-lock flag survives the return to IDLE for readout
   always_ff @(posedge i_clk) begin
      if (i_rst || w_enter_align) r_fail <= 1'b0;
      else if (w_give_up)         r_fail <= 1'b1;
   end

`ifdef LOOPBACK_ERR_INJECT_EN
   logic r_inj_armed;

   // One-shot injection: arm in RUN, invert the next transmitted bit only
   always_ff @(posedge i_clk) begin
      if (i_rst || (r_state != ST_RUN))      r_inj_armed <= 1'b0;
      else if (w_tick && r_inj_armed)        r_inj_armed <= 1'b0;
      else if (i_inject_err && !r_inj_armed) r_inj_armed <= 1'b1;
   end

   assign w_inj_flip = r_inj_armed;
`else
   assign w_inj_flip = 1'b0;
`endif

   assign o_tx_out  = r_tx;
   assign o_busy    = w_busy;
   assign o_locked  = (r_state == ST_RUN);
   assign o_lat     = r_lat;
   assign o_err_cnt = r_err;
   assign o_fail    = r_fail;

endmodule

// File: doc/loopback_checker.md
Name: loopback_checker

Overview:
- Drives a PRBS7 bit stream out of one expansion-board pin and receives it back on another pin, either through a direct wire or through the board's inverter test path.
- Finds the loop latency automatically, locks to it, then counts bit errors.
- Used as the far-end check for board I/O bring-up: pin continuity, polarity and latency on each header.

Parameters:
- DIV, 50: clk cycles per transmitted bit (≥4).
- SYNC_STAGES, 2: synchronizer flops on rx_in (≥2).
- MAX_LAT, 7: largest loop latency searched, in bit periods.
- LOCK_LEN, 16: consecutive matching samples required to declare lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; 1 = run test, 0 = stop
- expect_inv  in  1  1 = loop path inverts, so rx is compared against ~tx
- rx_in  in  1  returned pin, asynchronous to clk
- tx_out  out  1  transmitted pin, registered
- busy  out  1  high in ALIGN or RUN
- locked  out  1  high in RUN
- lat  out  3  locked latency in bit periods; width fixed for MAX_LAT ≤ 7
- err_cnt  out  ERR_W  mismatches counted in RUN, saturating
- fail  out  1  sticky: no lock found

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: tx_out=0, busy=0, locked=0, lat=0, err_cnt=0, fail=0, state=IDLE, LFSR=7'h7F, history=0.
- Bit timer: counts 0..DIV-1 while busy.
  - Bit tick at count DIV-1. On each tick the LFSR advances: polynomial x^7+x^6+1, shift left, feedback = bit6^bit5. tx_out <= new bit6.
  - Sample strobe at count DIV/2 (integer division).
- History register: MAX_LAT+1 bits, shifted on each tick. history[0] is the bit currently on tx_out; history[k] is the bit sent k periods earlier.
- Synchronizer: rx_in passes through SYNC_STAGES flops. rx_s is the last stage. No other logic uses raw rx_in.
- Expected value: exp = history[cand] ^ expect_inv, evaluated at the sample strobe.
- IDLE:
  - tx_out=0 and timer held at 0.
  - start=1 → ALIGN. On entry: cand=0, match=0, err_cnt=0, fail=0, LFSR reloaded to 7'h7F, history cleared.
- ALIGN:
  - Ignore strobes until MAX_LAT+1 ticks have elapsed, so history is fully populated.
  - After that, on each strobe:
    - rx_s==exp → match+1. When match reaches LOCK_LEN → RUN, lat=cand, locked=1.
    - Mismatch → match=0, cand+1.
    - Mismatch with cand==MAX_LAT → FAIL.
- RUN:
  - On each strobe, rx_s!=exp with cand=lat → err_cnt+1.
  - err_cnt saturates at all-ones. Wrap-around is forbidden.
- FAIL:
  - fail=1, busy=0, tx_out=0.
  - Remain in FAIL until start=0, then go to IDLE. fail stays set until the next ALIGN entry.
- start=0 in ALIGN or RUN → IDLE on the next edge.
  - locked, busy → 0. err_cnt and lat are held for readout.
- Simultaneous events: rst overrides everything. start=0 overrides a lock or an error in the same cycle.
- rst mid-operation: all outputs return to reset values on the next edge. No partial state survives.

Optional Feature:
- Macro: LOOPBACK_ERR_INJECT_EN.
- Defined:
  - Adds input port inject_err (1 bit) after rx_in.
  - A 1-cycle pulse in RUN arms a flag. The next bit tick sends ~LFSR bit on tx_out, but history records the uninverted bit. The flag then clears.
  - Pulses while already armed, or outside RUN, are ignored.
  - Expected result: exactly one err_cnt increment per injection.
- Not defined: the port is absent, and tx_out always equals the LFSR bit.

Test Plan:
- Direct loop, expect_inv=0, DIV=4, rx_in=tx_out delayed 2 bit periods, start=1 → locked=1, lat=2, err_cnt=0 after 3000 cycles.
- Inverted loop through an inverter with 3-bit delay, expect_inv=1 → lat=3, locked=1, err_cnt=0. Same loop with expect_inv=0 → fail=1, locked never asserted.
- rx_in tied 0, start=1 → fail=1, busy=0 within (MAX_LAT+1)·(LOCK_LEN+8+MAX_LAT+1)·DIV cycles. tx_out=0 afterwards.
- With LOOPBACK_ERR_INJECT_EN defined, locked, 5 inject_err pulses spaced 20 bits apart → err_cnt=5. Pulse outside RUN → no change.
- ERR_W=4, lock on a direct loop, then force rx_in inverted for 40 bits → err_cnt=15 and holds. start=0 → IDLE, err_cnt stays 15. start=1 → err_cnt=0.
- rst=1 for one cycle mid-RUN → next edge: tx_out=0, busy=0, locked=0, lat=0, err_cnt=0, fail=0. Restart relocks to the same lat.
